// File: rtl/trig_capture_if.sv
// trig_capture_if
// Bundles the command, sample-strobe, trigger and RAM-write signals of the
// capture controller.
//   master : command/trigger side. It drives arm, clr_done, smpl_en, the
//            trigger levels, trig_en and trig_pos. It observes the RAM
//            write port and the status outputs.
//   slave  : trig_capture itself.
interface trig_capture_if #(
   parameter int ADDR_W = 9
);
   logic              arm;
   logic              clr_done;
   logic              smpl_en;
   logic              SPItrig;
   logic              UARTtrig;
   logic              chan_trig;
   logic [2:0]        trig_en;
   logic [ADDR_W-1:0] trig_pos;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic              armed;
   logic              triggered;
   logic              capture_done;
   logic [ADDR_W-1:0] start_addr;

   modport master (
      output arm, clr_done, smpl_en, SPItrig, UARTtrig, chan_trig, trig_en, trig_pos,
      input  we, waddr, armed, triggered, capture_done, start_addr
   );

   modport slave (
      input  arm, clr_done, smpl_en, SPItrig, UARTtrig, chan_trig, trig_en, trig_pos,
      output we, waddr, armed, triggered, capture_done, start_addr
   );
endinterface

// File: rtl/trig_capture.sv
// trig_capture
// Capture controller for a circular sample RAM. A capture starts with an arm
// pulse. Decimated samples are then written on every smpl_en strobe. Once the
// pre-trigger part of the buffer is full, the first enabled trigger source is
// accepted. After that, trig_pos further samples are recorded and the capture
// is flagged complete. start_addr then points at the oldest stored sample.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   bus      : trig_capture_if.slave, which carries the following signals
//      arm / clr_done  command pulses (start capture / acknowledge done)
//      smpl_en         decimated sample strobe
//      SPItrig, UARTtrig, chan_trig, trig_en : trigger levels and enable mask
//      trig_pos        post-trigger sample count, latched at arm
//      we, waddr       RAM write port
//      armed, triggered, capture_done, start_addr : status
module trig_capture #(
   parameter int ADDR_W = 9
) (
   input  logic          clk,
   input  logic          rst,
   trig_capture_if.slave bus
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ARMED = 2'd1;
   localparam logic [1:0] S_POST  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [ADDR_W:0]   DEPTH_C  = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   logic [1:0]        state_q,     state_d;
   logic [ADDR_W-1:0] waddr_q,     waddr_d;
   logic [ADDR_W:0]   pre_cnt_q,   pre_cnt_d;
   logic [ADDR_W:0]   post_cnt_q,  post_cnt_d;
   logic [ADDR_W-1:0] trig_pos_q,  trig_pos_d;
   logic              triggered_q, triggered_d;

   logic [ADDR_W:0]   need;
   logic              trig_hit;
   logic              we;
   logic              accept;
   logic              post_last;

   // The pre-trigger region must hold DEPTH - trig_pos samples before a
   // trigger is accepted. With trig_pos = 0 the whole buffer is pre-trigger.
   assign need     = DEPTH_C - {1'b0, trig_pos_q};
   assign trig_hit = |(bus.trig_en & {bus.chan_trig, bus.UARTtrig, bus.SPItrig});

   // Write uses the current waddr. It is gated by rst so that no write
   // escapes while the state is being forced back to IDLE.
   assign we = ~rst & bus.smpl_en & ((state_q == S_ARMED) | (state_q == S_POST));

   // A trigger arriving before the pre-trigger region is full is dropped,
   // not queued. The compare uses the registered pre_cnt, so a write in the
   // acceptance cycle is still counted as pre-trigger.
   assign accept    = (state_q == S_ARMED) & trig_hit & (pre_cnt_q >= need);
   assign post_last = (state_q == S_POST) & bus.smpl_en &
                      ((post_cnt_q + CNT_ONE) == {1'b0, trig_pos_q});

   always_comb begin
      state_d     = state_q;
      waddr_d     = waddr_q;
      pre_cnt_d   = pre_cnt_q;
      post_cnt_d  = post_cnt_q;
      trig_pos_d  = trig_pos_q;
      triggered_d = triggered_q;

      if (we) begin
         waddr_d = waddr_q + ADDR_ONE;
      end

      case (state_q)
         S_ARMED: begin
            if (bus.smpl_en && (pre_cnt_q != DEPTH_C)) begin
               pre_cnt_d = pre_cnt_q + CNT_ONE;
            end
            if (accept) begin
               triggered_d = 1'b1;
               post_cnt_d  = '0;
               state_d     = (trig_pos_q == '0) ? S_DONE : S_POST;
            end
         end
         S_POST: begin
            if (bus.smpl_en) begin
               post_cnt_d = post_cnt_q + CNT_ONE;
            end
            if (post_last) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (bus.clr_done) begin
               state_d     = S_IDLE;
               triggered_d = 1'b0;
            end
         end
         default: begin
         end
      endcase

      // A new arm overrides everything above, from any state.
      if (bus.arm) begin
         state_d     = S_ARMED;
         waddr_d     = '0;
         pre_cnt_d   = '0;
         post_cnt_d  = '0;
         trig_pos_d  = bus.trig_pos;
         triggered_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         waddr_q     <= '0;
         pre_cnt_q   <= '0;
         post_cnt_q  <= '0;
         trig_pos_q  <= '0;
         triggered_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         waddr_q     <= waddr_d;
         pre_cnt_q   <= pre_cnt_d;
         post_cnt_q  <= post_cnt_d;
         trig_pos_q  <= trig_pos_d;
         triggered_q <= triggered_d;
      end
   end

   assign bus.we           = we;
   assign bus.waddr        = waddr_q;
   assign bus.armed        = (state_q == S_ARMED);
   assign bus.triggered    = triggered_q;
   assign bus.capture_done = (state_q == S_DONE);
   // In DONE the buffer is full, so the next address to be written holds
   // the oldest sample.
   assign bus.start_addr   = (state_q == S_DONE) ? waddr_q : '0;

endmodule

// File: doc/trig_capture.md
# trig_capture

Capture controller sitting directly downstream of the protocol trigger units (SPI/UART) and the channel trigger logic. It arms on command, writes decimated samples into a circular sample RAM, and qualifies the incoming trigger sources against an enable mask. After a trigger it records a programmable number of post-trigger samples, then flags capture complete and reports the address of the oldest stored sample for readback.

## Interface
- ADDR_W, 9, sample RAM address width; DEPTH = 2^ADDR_W entries
- clk  in  1  system clock; all logic on posedge
- rst  in  1  synchronous reset, active-high
- arm  in  1  single-cycle pulse from the command handler: start a new capture
- clr_done  in  1  single-cycle pulse: acknowledge a finished capture, return to IDLE
- smpl_en  in  1  decimated sample strobe; one RAM write per strobe while capturing
- SPItrig  in  1  SPI protocol trigger (level)
- UARTtrig  in  1  UART protocol trigger (level)
- chan_trig  in  1  channel edge/level trigger (level)
- trig_en  in  3  enable mask {chan, UART, SPI}; bit 0 = SPItrig
- trig_pos  in  ADDR_W  number of post-trigger samples; sampled at arm
- we  out  1  RAM write enable
- waddr  out  ADDR_W  RAM write address
- armed  out  1  high in PRETRIG/ARMED
- triggered  out  1  high from trigger acceptance until IDLE
- capture_done  out  1  high in DONE
- start_addr  out  ADDR_W  oldest valid sample address; valid while capture_done

## Operation
- States: IDLE, ARMED, POSTTRIG, DONE.
- trig_pos latched into trig_pos_q on arm; changes to trig_pos mid-capture ignored.
- pre_cnt (ADDR_W+1 bits) cleared on arm, increments on each smpl_en in ARMED, saturates at DEPTH.
- need = DEPTH - trig_pos_q (ADDR_W+1 bits; trig_pos_q = 0 -> need = DEPTH).
- trig_hit = |(trig_en & {chan_trig, UARTtrig, SPItrig}).
- IDLE: we = 0; arm -> ARMED, waddr <= 0.
- ARMED: we = smpl_en; trigger accepted when trig_hit && pre_cnt >= need (registered pre_cnt). Sample written in the acceptance cycle counts as pre-trigger. Accept -> POSTTRIG (trig_pos_q != 0) or DONE (trig_pos_q == 0). trig_hit below need is ignored, not remembered.
- POSTTRIG: we = smpl_en; post_cnt cleared on entry, increments per smpl_en; on the write making post_cnt == trig_pos_q -> DONE.
- DONE: we = 0; start_addr = waddr (next address to be written = oldest sample, buffer full). clr_done -> IDLE.
- waddr increments by 1 after every write, wraps DEPTH-1 -> 0.
- Priority: rst > arm > clr_done > state transitions. arm in any state (including POSTTRIG, DONE) restarts: ARMED, waddr/pre_cnt/post_cnt cleared, triggered cleared. clr_done outside DONE ignored.
- triggered set on acceptance, cleared on arm or entry to IDLE.

## Timing
- Reset: state IDLE, we = 0, waddr = 0, armed = 0, triggered = 0, capture_done = 0, start_addr = 0, counters 0.
- we is combinational from smpl_en and state; waddr registered (write uses current waddr).
- arm at cycle N -> armed = 1 at N+1; a smpl_en at N+1 writes address 0.
- Trigger accepted at cycle T -> triggered = 1 at T+1.
- Last post-trigger write at cycle P -> capture_done = 1 at P+1, we = 0 from P+1.
- trig_pos_q = 0: acceptance at T -> triggered and capture_done both 1 at T+1.
- Trigger sources are level, already synchronized upstream; no edge detection here.

## Test plan
- Reset: assert rst 2 cycles with arm/smpl_en high -> all outputs 0, state IDLE, no writes.
- ADDR_W=4, trig_pos=4, trig_en=001, smpl_en every cycle, SPItrig held high from arm -> writes addr 0..11 ignored for trigger, acceptance on write to addr 12, post writes 13,14,15,0, capture_done next cycle, 17 writes total, start_addr = 1.
- Mask: trig_en=001, UARTtrig high after pre-fill -> no trigger; then SPItrig 1-cycle pulse -> triggered = 1 next cycle.
- trig_pos=0, pre-fill 16 samples, chan_trig with trig_en=100 -> triggered and capture_done rise same cycle, exactly 1 write after threshold in acceptance cycle.
- smpl_en every 3rd cycle, trig_pos=2 -> pre_cnt/post_cnt advance only on strobes; done after 2nd strobe following trigger; we never high without smpl_en.
- arm during POSTTRIG -> restart, waddr = 0, triggered = 0; clr_done in DONE -> IDLE; clr_done in ARMED ignored; rst mid-POSTTRIG -> reset values next cycle.
